// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one registered arithmetic_shift datapath
module arithmetic_shift #(
    parameter int SIZE = 64,
    parameter int SW   = $clog2(SIZE) + 2
) (
    input  logic [SIZE-1:0] a,
    input  logic            right,
    input  logic [SW-1:0]   shift,
    output logic [SIZE-1:0] b
);

    localparam logic [SW-1:0] SIZE_SW = SW'(SIZE);

    logic [SIZE-2:0] low;

    assign low = a[SIZE-2:0];

    // Right shifts keep the MSB in place and shift only the lower SIZE-1 bits, so it never smears downward.
    always_comb begin
        b = '0;
        if (right) begin
            b[SIZE-1] = a[SIZE-1];
            if (shift < SIZE_SW) begin
                b[SIZE-2:0] = low >> shift;
            end
        end else if (shift < SIZE_SW) begin
            b = a << shift;
        end
    end

endmodule

module shift_arbiter #(
    parameter int SIZE = 64,
    parameter int NREQ = 2,
    localparam int SW  = $clog2(SIZE) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*SIZE-1:0] i_req_a,
    input  logic [NREQ-1:0]      i_req_right,
    input  logic [NREQ*SW-1:0]   i_req_shift,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [SIZE-1:0]      o_rsp_b,
    output logic                 o_busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   winner;
    logic            win_found;
    int              idx;
    logic [SIZE-1:0] op_a;
    logic            op_right;
    logic [SW-1:0]   op_shift;
    logic [SIZE-1:0] shift_out;
    logic [SIZE-1:0] res;
    logic            rsp_done;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                winner    = PW'(idx);
            end
        end
    end

    assign rsp_done = (state == RESP) && i_rsp_ready[gnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = SHIFT;
            SHIFT:   state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        if (state == IDLE && win_found) begin
            o_req_ready[winner] = 1'b1;
        end
        if (state == RESP) begin
            o_rsp_valid[gnt] = 1'b1;
        end
        o_busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            gnt      <= '0;
            op_a     <= '0;
            op_right <= 1'b0;
            op_shift <= '0;
            res      <= '0;
        end else begin
            if (state == IDLE && win_found) begin
                gnt      <= winner;
                op_a     <= i_req_a[int'(winner)*SIZE +: SIZE];
                op_right <= i_req_right[winner];
                op_shift <= i_req_shift[int'(winner)*SW +: SW];
            end
            if (state == SHIFT) begin
                res <= shift_out;
            end
            // The just-served requester drops to lowest priority.
            if (rsp_done) begin
                rr_ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
            end
        end
    end

    arithmetic_shift #(
        .SIZE (SIZE),
        .SW   (SW)
    ) u_shift (
        .a     (op_a),
        .right (op_right),
        .shift (op_shift),
        .b     (shift_out)
    );

    assign o_rsp_b = res;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter against a reference shift model
module tb_shift_arbiter;

    localparam int SIZE  = 64;
    localparam int NREQ  = 2;
    localparam int SW    = $clog2(SIZE) + 2;
    localparam int N_TXN = 10000;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*SIZE-1:0] i_req_a;
    logic [NREQ-1:0]      i_req_right;
    logic [NREQ*SW-1:0]   i_req_shift;
    logic [NREQ-1:0]      o_rsp_valid;
    logic [NREQ-1:0]      i_rsp_ready;
    logic [SIZE-1:0]      o_rsp_b;
    logic                 o_busy;

    int n_checks;
    int n_fail;

    shift_arbiter #(
        .SIZE (SIZE),
        .NREQ (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_right (i_req_right),
        .i_req_shift (i_req_shift),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_b     (o_rsp_b),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Right: MSB stays put, remaining 63-bit magnitude divided by 2^sh. Left: multiply by 2^sh mod 2^64.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input bit right, input int sh);
        logic [63:0] mag;
        if (right) begin
            mag = a & 64'h7FFF_FFFF_FFFF_FFFF;
            if (sh >= 63) mag = 64'd0;
            else          mag = mag / (64'd1 << sh);
            return (a & 64'h8000_0000_0000_0000) | mag;
        end
        if (sh >= 64) return 64'd0;
        return a * (64'd1 << sh);
    endfunction

    task automatic do_reset(input int n);
        rst         = 1'b1;
        i_req_valid = '0;
        i_rsp_ready = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [63:0] a, input bit r, input int sh);
        i_req_a[k*SIZE +: SIZE] = a;
        i_req_right[k]          = r;
        i_req_shift[k*SW +: SW] = SW'(sh);
    endtask

    task automatic do_txn(input int k, input logic [63:0] a, input bit r, input int sh,
                          input int stall, input bit other_valid, output logic [63:0] b);
        int o;
        o = 1 - k;
        set_req(k, a, r, sh);
        i_rsp_ready    = '0;
        i_req_valid    = '0;
        i_req_valid[k] = 1'b1;
        @(negedge clk);
        check("txn_ready", 64'(o_req_ready), 64'(1 << k));
        @(posedge clk); #1;
        i_req_valid    = '0;
        i_req_valid[o] = other_valid;
        @(negedge clk);
        check("txn_shift_busy", 64'(o_busy), 64'd1);
        check("txn_shift_novalid", 64'(o_rsp_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("txn_rsp_valid", 64'(o_rsp_valid), 64'(1 << k));
        b = o_rsp_b;
        repeat (stall) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_valid", 64'(o_rsp_valid), 64'(1 << k));
            check("stall_b", o_rsp_b, b);
            check("stall_noready", 64'(o_req_ready), 64'd0);
        end
        i_rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = '0;
        i_req_valid = '0;
        @(negedge clk);
        check("txn_done_valid", 64'(o_rsp_valid), 64'd0);
        check("txn_done_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic mid_reset(input bit in_resp);
        logic [63:0] b;
        do_txn(0, 64'h10, 1'b0, 1, 0, 1'b0, b);
        set_req(0, 64'h55, 1'b0, 2);
        i_req_valid = 2'b01;
        @(negedge clk);
        check("mr_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        i_req_valid = '0;
        if (in_resp) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("mr_in_resp", 64'(o_rsp_valid), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_valid_cleared", 64'(o_rsp_valid), 64'd0);
        check("mr_busy_cleared", 64'(o_busy), 64'd0);
        check("mr_b_cleared", o_rsp_b, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("mr_no_response", 64'(o_rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        i_req_valid = 2'b11;
        @(negedge clk);
        check("mr_first_grant", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        i_req_valid = '0;
        do_reset(1);
    endtask

    initial begin
        logic [63:0]     b;
        logic [63:0]     exp_b;
        logic [NREQ-1:0] rdy;
        int grants, rsps, last_g, w, ew, ri, ptr_m, n_acc, n_rsp;
        bit outstanding;
        int exp_idx;
        bit active[NREQ];
        bit acc_flag[NREQ];

        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        i_req_valid = '0;
        i_rsp_ready = '0;
        i_req_a     = '0;
        i_req_right = '0;
        i_req_shift = '0;

        do_reset(2);
        @(negedge clk);
        check("rst_ready", 64'(o_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_rsp_b", o_rsp_b, 64'd0);
        @(posedge clk); #1;

        do_txn(0, 64'h0000_0000_0000_00F0, 1'b0, 4, 0, 1'b0, b);
        check("left_f0_by4", b, 64'h0000_0000_0000_0F00);
        do_txn(1, 64'h8000_0000_0000_0100, 1'b1, 8, 0, 1'b0, b);
        check("right_sign_by8", b, 64'h8000_0000_0000_0001);
        do_txn(0, 64'h8000_0000_0000_0100, 1'b1, 64, 0, 1'b0, b);
        check("right_by64", b, 64'h8000_0000_0000_0000);
        do_txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 0, 1'b0, b);
        check("left_by64", b, 64'd0);
        do_txn(0, 64'hC000_0000_0000_0000, 1'b1, 1, 0, 1'b0, b);
        check("right_no_smear", b, 64'hA000_0000_0000_0000);
        do_txn(1, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 5, 1'b1, b);
        check("backpressure_b", b, 64'h0123_4567_89AB_CDEF);

        // Contention from reset: grants must alternate 0,1,0,1.
        do_reset(2);
        set_req(0, 64'h1234, 1'b0, 4);
        set_req(1, 64'h8000_0000_0000_00F0, 1'b1, 4);
        i_req_valid = 2'b11;
        i_rsp_ready = 2'b11;
        grants = 0;
        rsps   = 0;
        last_g = -1;
        for (int c = 0; c < 40 && rsps < 4; c++) begin
            @(negedge clk);
            rdy = o_req_ready;
            if (rdy != '0) begin
                last_g = rdy[1] ? 1 : 0;
                check("cont_grant", 64'(last_g), 64'(grants % 2));
                grants++;
            end
            if (o_rsp_valid != '0) begin
                ri = o_rsp_valid[1] ? 1 : 0;
                check("cont_rsp_idx", 64'(ri), 64'(last_g));
                check("cont_rsp_b", o_rsp_b, (ri == 0) ? 64'h12340 : 64'h8000_0000_0000_000F);
                rsps++;
            end
            @(posedge clk); #1;
            if (grants >= 4) i_req_valid = '0;
        end
        check("cont_grants", 64'(grants), 64'd4);
        check("cont_rsps", 64'(rsps), 64'd4);
        do_reset(1);

        mid_reset(1'b0);
        mid_reset(1'b1);

        // Random regression against the reference model and fairness rule.
        do_reset(2);
        ptr_m       = 0;
        outstanding = 1'b0;
        exp_idx     = 0;
        exp_b       = '0;
        n_acc       = 0;
        n_rsp       = 0;
        for (int k = 0; k < NREQ; k++) begin
            active[k]   = 1'b0;
            acc_flag[k] = 1'b0;
        end
        for (int c = 0; c < 80000 && n_rsp < N_TXN; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NREQ; k++) begin
                if (acc_flag[k]) begin
                    active[k]   = 1'b0;
                    acc_flag[k] = 1'b0;
                end
                if (!active[k]) begin
                    if (n_acc < N_TXN && $urandom_range(1, 0) == 1) begin
                        active[k] = 1'b1;
                        set_req(k, {$urandom, $urandom}, 1'($urandom_range(1, 0)),
                                int'($urandom_range(SIZE + 3, 0)));
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    active[k] = 1'b0;
                end
                i_req_valid[k] = active[k];
                i_rsp_ready[k] = ($urandom_range(3, 0) != 0);
            end
            @(negedge clk);
            rdy = o_req_ready;
            if (rdy != '0) begin
                w = rdy[1] ? 1 : 0;
                check("rnd_ready_onehot", 64'($countones(rdy)), 64'd1);
                ew = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (ew < 0 && i_req_valid[(ptr_m + i) % NREQ]) ew = (ptr_m + i) % NREQ;
                end
                check("rnd_grant_order", 64'(w), 64'(ew));
                check("rnd_no_overlap", 64'(outstanding), 64'd0);
                exp_b = ref_shift(i_req_a[w*SIZE +: SIZE], i_req_right[w],
                                  int'(i_req_shift[w*SW +: SW]));
                exp_idx     = w;
                outstanding = 1'b1;
                ptr_m       = (w + 1) % NREQ;
                acc_flag[w] = 1'b1;
                n_acc++;
            end else if (!o_busy && i_req_valid != '0) begin
                check("rnd_idle_grant", 64'd0, 64'd1);
            end
            if (o_rsp_valid != '0) begin
                ri = o_rsp_valid[1] ? 1 : 0;
                check("rnd_rsp_onehot", 64'($countones(o_rsp_valid)), 64'd1);
                check("rnd_rsp_expected", 64'(outstanding), 64'd1);
                check("rnd_rsp_idx", 64'(ri), 64'(exp_idx));
                if (i_rsp_ready[ri]) begin
                    check("rnd_rsp_data", o_rsp_b, exp_b);
                    outstanding = 1'b0;
                    n_rsp++;
                end
            end
        end
        check("rnd_accepted", 64'(n_acc), 64'(N_TXN));
        check("rnd_responded", 64'(n_rsp), 64'(N_TXN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
